rv_alu_arb: RTL and testbench

Shared-ALU arbiter and sequencer: accepts operation requests from `NREQ` requesters, grants one at a time round-robin, drives the operands and op-select of a single external `rv_alu` instance, registers the result and returns it to the winning requester with a valid/ready handshake. It sits in the execute stage between the issue ports (integer pipe, address/branch helpers) and the one ALU they share.

---
 rtl/rv_alu_pkg.sv | 31 +++
 rtl/rv_alu_arb_if.sv | 29 ++
 rtl/rv_rr_arbiter.sv | 36 +++
 rtl/rv_alu_arb.sv | 133 +++++++++++++
 tb/tb_rv_alu_arb.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_alu_pkg.sv
// Shared definitions for the rv_alu_arb shared-ALU arbiter:
// ALU op-select encodings, arbiter FSM states and the legal-select helper.
package rv_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SRA  = 4'hD;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // True when the op-select is one the ALU actually implements.
  function automatic logic sel_is_legal(input logic [3:0] sel);
    case (sel)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: sel_is_legal = 1'b1;
      default:                                    sel_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_arb_if.sv
// Requester-side bus of rv_alu_arb: packed per-requester request channel
// and the shared response channel. The arbiter uses the slave view, the
// requesters (or a testbench) the master view.
interface rv_alu_arb_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 64
);

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*XLEN-1:0] req_op1_i;
  logic [NREQ*XLEN-1:0] req_op2_i;
  logic [NREQ*4-1:0]    req_sel_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [XLEN-1:0]      rsp_data_o;
  logic                 rsp_err_o;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_sel_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_sel_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

endinterface

// File: rtl/rv_rr_arbiter.sv
// Round-robin grant selection: starting after the last granted index,
// pick the first active request. Purely combinational; the owner of the
// pointer decides when it advances.
module rv_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // Walk ptr+1, ptr+2, ... modulo NREQ and grant the first requester found.
  always_comb begin
    int              sum;
    logic [IDXW-1:0] cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = sum[IDXW-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rv_alu_arb.sv
// rv_alu_arb: shares one external rv_alu between NREQ requesters.
// IDLE grants one requester round-robin and latches its operands, EXEC lets
// the ALU compute from the operand registers, RESP holds the registered
// result until the owning requester accepts it.
// Optional build macro RV_ALU_ARB_OPCHK_EN: flags illegal op-selects at
// grant time and returns rsp_err_o=1 with zero data instead of the ALU value.
module rv_alu_arb
  import rv_alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  rv_alu_arb_if.slave     bus,
  output logic [XLEN-1:0] alu_op1_o,
  output logic [XLEN-1:0] alu_op2_o,
  output logic [3:0]      alu_sel_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] ptr_q;
  logic [NREQ-1:0] owner_q;
  logic [XLEN-1:0] op1_q, op2_q, result_q;
  logic [3:0]      sel_q;

  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            grant_fire;
  logic [XLEN-1:0] grant_op1, grant_op2, exec_result;
  logic [3:0]      grant_sel;

  rv_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Route the winning requester's operands and op-select toward the registers.
  always_comb begin
    grant_op1 = '0;
    grant_op2 = '0;
    grant_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        grant_op1 = bus.req_op1_i[k*XLEN +: XLEN];
        grant_op2 = bus.req_op2_i[k*XLEN +: XLEN];
        grant_sel = bus.req_sel_i[k*4 +: 4];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the handshake outputs; only the owner's ready ends RESP.
  always_comb begin
    state_d         = state_q;
    grant_fire      = 1'b0;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready_o = gnt;
        if (gnt_valid) begin
          grant_fire = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid_o = owner_q;
        if (|(bus.rsp_ready_i & owner_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/owner capture on grant, result capture at the end of EXEC.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q    <= IDXW'(NREQ - 1);
      owner_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
    end else begin
      if (grant_fire) begin
        ptr_q   <= gnt_idx;
        owner_q <= gnt;
        op1_q   <= grant_op1;
        op2_q   <= grant_op2;
        sel_q   <= grant_sel;
      end
      if (state_q == ST_EXEC) result_q <= exec_result;
    end
  end

`ifdef RV_ALU_ARB_OPCHK_EN
  logic err_q;

  // Remember whether the granted op-select is outside the implemented set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        err_q <= 1'b0;
    else if (grant_fire) err_q <= !sel_is_legal(grant_sel);
  end

  assign exec_result   = err_q ? '0 : alu_result_i;
  assign bus.rsp_err_o = err_q && (state_q == ST_RESP);
`else
  assign exec_result   = alu_result_i;
  assign bus.rsp_err_o = 1'b0;
`endif

  assign alu_op1_o      = op1_q;
  assign alu_op2_o      = op2_q;
  assign alu_sel_o      = sel_q;
  assign bus.rsp_data_o = result_q;

endmodule

// File: tb/tb_rv_alu_arb.sv
// Directed testbench for rv_alu_arb with two requesters and a behavioural
// stand-in for the external rv_alu. Expected values are hand-computed.
module tb_rv_alu_arb;
  import rv_alu_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 64;

`ifdef RV_ALU_ARB_OPCHK_EN
  localparam logic EXP_ILLEGAL_ERR = 1'b1;
`else
  localparam logic EXP_ILLEGAL_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] alu_op1, alu_op2, alu_result;
  logic [3:0]      alu_sel;
  int              checks = 0;
  int              errors = 0;

  rv_alu_arb_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  rv_alu_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .bus          (bus),
    .alu_op1_o    (alu_op1),
    .alu_op2_o    (alu_op2),
    .alu_sel_o    (alu_sel),
    .alu_result_i (alu_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU; unknown selects produce 0.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_ADD:  alu_result = alu_op1 + alu_op2;
      ALU_SUB:  alu_result = alu_op1 - alu_op2;
      ALU_SLL:  alu_result = alu_op1 << alu_op2[5:0];
      ALU_SLT:  alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 64'd1 : 64'd0;
      ALU_SLTU: alu_result = (alu_op1 < alu_op2) ? 64'd1 : 64'd0;
      ALU_XOR:  alu_result = alu_op1 ^ alu_op2;
      ALU_SRL:  alu_result = alu_op1 >> alu_op2[5:0];
      ALU_SRA:  alu_result = $signed(alu_op1) >>> alu_op2[5:0];
      ALU_OR:   alu_result = alu_op1 | alu_op2;
      ALU_AND:  alu_result = alu_op1 & alu_op2;
      default:  alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] s);
    bus.req_op1_i[k*XLEN +: XLEN] = a;
    bus.req_op2_i[k*XLEN +: XLEN] = b;
    bus.req_sel_i[k*4 +: 4]       = s;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    bus.req_op1_i   = '0;
    bus.req_op2_i   = '0;
    bus.req_sel_i   = '0;
    tick();
    tick();
    checks++;
    if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_hs: ready=%b valid=%b, required 00/00", bus.req_ready_o, bus.rsp_valid_o);
    end
    checks++;
    if (bus.rsp_data_o !== 64'd0 || bus.rsp_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: data=%h err=%b, required 0/0", bus.rsp_data_o, bus.rsp_err_o);
    end
    checks++;
    if (alu_op1 !== 64'd0 || alu_op2 !== 64'd0 || alu_sel !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_alu: op1=%h op2=%h sel=%h, required 0", alu_op1, alu_op2, alu_sel);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive_req(0, 64'd5, 64'd3, ALU_SUB);
    bus.req_valid_i = 2'b01;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_grant: ready=%b, required 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    checks++;
    if (alu_op1 !== 64'd5 || alu_op2 !== 64'd3 || alu_sel !== ALU_SUB || bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_exec: op1=%h op2=%h sel=%h valid=%b, required 5/3/8/00",
               alu_op1, alu_op2, alu_sel, bus.rsp_valid_o);
    end
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 64'd2) begin
      errors++;
      $display("[TB] FAIL single_rsp: valid=%b data=%h, required 01/2", bus.rsp_valid_o, bus.rsp_data_o);
    end
    checks++;
    if (alu_op1 !== 64'd5 || alu_sel !== ALU_SUB) begin
      errors++;
      $display("[TB] FAIL single_alu_hold: op1=%h sel=%h, required 5/8", alu_op1, alu_sel);
    end
    bus.rsp_ready_i = 2'b01;
    tick();
    bus.rsp_ready_i = 2'b00;
    checks++;
    if (bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_done: valid=%b, required 00", bus.rsp_valid_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_oh;
    logic [63:0] exp_data;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_req(0, 64'd1, 64'd1, ALU_ADD);
    drive_req(1, 64'hF, 64'h3, ALU_XOR);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_oh   = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (n % 2 == 0) ? 64'd2 : 64'hC;
      checks++;
      if (bus.req_ready_o !== exp_oh) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: ready=%b, required %b", n, bus.req_ready_o, exp_oh);
      end
      tick();
      tick();
      checks++;
      if (bus.rsp_valid_o !== exp_oh || bus.rsp_data_o !== exp_data) begin
        errors++;
        $display("[TB] FAIL rr_rsp[%0d]: valid=%b data=%h, required %b/%h",
                 n, bus.rsp_valid_o, bus.rsp_data_o, exp_oh, exp_data);
      end
      tick();
    end
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
  endtask

  task automatic test_backpressure();
    drive_req(0, 64'h8000_0000_0000_0000, 64'd4, ALU_SRA);
    bus.req_valid_i = 2'b01;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_grant: ready=%b, required 01", bus.req_ready_o);
    end
    tick();
    drive_req(1, 64'd2, 64'd3, ALU_ADD);
    bus.req_valid_i = 2'b10;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_exec_ready: ready=%b, required 00", bus.req_ready_o);
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 64'hF800_0000_0000_0000) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b data=%h, required 01/f800000000000000",
                 c, bus.rsp_valid_o, bus.rsp_data_o);
      end
      checks++;
      if (bus.req_ready_o !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bp_ready[%0d]: ready=%b, required 00", c, bus.req_ready_o);
      end
      tick();
    end
    bus.rsp_ready_i = 2'b01;
    tick();
    bus.rsp_ready_i = 2'b00;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_waiter_grant: ready=%b, required 10", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== 64'd5) begin
      errors++;
      $display("[TB] FAIL bp_waiter_rsp: valid=%b data=%h, required 10/5", bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.rsp_ready_i = 2'b10;
    tick();
    bus.rsp_ready_i = 2'b00;
  endtask

  task automatic test_wrong_owner();
    drive_req(0, 64'hFF, 64'h0F, ALU_AND);
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    bus.rsp_ready_i = 2'b10;
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 64'h0F) begin
      errors++;
      $display("[TB] FAIL wrong_owner: valid=%b data=%h, required 01/0f", bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.rsp_ready_i = 2'b01;
    tick();
    bus.rsp_ready_i = 2'b00;
    checks++;
    if (bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL owner_accept: valid=%b, required 00", bus.rsp_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    drive_req(0, 64'd7, 64'd8, ALU_ADD);
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    checks++;
    if (alu_op1 !== 64'd7) begin
      errors++;
      $display("[TB] FAIL mid_exec: op1=%h, required 7", alu_op1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid_o !== 2'b00 || bus.rsp_data_o !== 64'd0 || bus.rsp_err_o !== 1'b0 ||
        alu_op1 !== 64'd0 || alu_op2 !== 64'd0 || alu_sel !== 4'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outs: valid=%b data=%h err=%b op1=%h op2=%h sel=%h, required all 0",
               bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o, alu_op1, alu_op2, alu_sel);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_no_rsp: valid=%b, required 00", bus.rsp_valid_o);
    end
    drive_req(1, 64'd1, 64'd1, ALU_OR);
    bus.req_valid_i = 2'b11;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_ptr_reset: ready=%b, required 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 64'd15) begin
      errors++;
      $display("[TB] FAIL mid_after_rsp: valid=%b data=%h, required 01/f", bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.rsp_ready_i = 2'b01;
    tick();
    bus.rsp_ready_i = 2'b00;
  endtask

  task automatic test_illegal_sel();
    drive_req(0, 64'd5, 64'd3, 4'h9);
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    checks++;
    if (bus.rsp_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_err_exec: err=%b, required 0", bus.rsp_err_o);
    end
    tick();
    checks++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 64'd0 || bus.rsp_err_o !== EXP_ILLEGAL_ERR) begin
      errors++;
      $display("[TB] FAIL illegal_rsp: valid=%b data=%h err=%b, required 01/0/%b",
               bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o, EXP_ILLEGAL_ERR);
    end
    bus.rsp_ready_i = 2'b01;
    tick();
    bus.rsp_ready_i = 2'b00;
    checks++;
    if (bus.rsp_err_o !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL illegal_err_clear: err=%b valid=%b, required 0/00", bus.rsp_err_o, bus.rsp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrong_owner();
    test_reset_mid();
    test_illegal_sel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
